// File: rtl/clint_timer_gen2_if.sv
// Valid/ready register port between the SoC register bridge (master) and the CLINT (slave).
interface clint_timer_gen2_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [63:0]           req_wdata_i;
  logic [7:0]            req_be_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [63:0]           rsp_rdata_o;
  logic                  rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/clint_timer_gen2.sv
// Core-local interruptor: prescaled 64-bit mtime, per-hart mtimecmp/msip, timer and software irqs.
// Define CLINT_DBG_HALT_EN to add debug_halt_i, which freezes the prescaler and mtime.
module clint_timer_gen2 #(
  parameter int unsigned NR_CORES       = 1,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned PRESCALE_RST   = 1,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
`ifdef CLINT_DBG_HALT_EN
  input  logic                debug_halt_i,
`endif
  clint_timer_gen2_if.slave   bus,
  output logic [NR_CORES-1:0] timer_irq_o,
  output logic [NR_CORES-1:0] ipi_o
);

  localparam int unsigned AW            = ADDR_WIDTH;
  localparam int unsigned PW            = PRESCALE_WIDTH;
  localparam int unsigned IDX_W         = (NR_CORES > 1) ? $clog2(NR_CORES) : 1;
  localparam int unsigned WIN_BYTES     = 8 * NR_CORES;
  localparam int unsigned MSIP_BASE     = 32'h0000;
  localparam int unsigned MTIMECMP_BASE = 32'h4000;
  localparam int unsigned PRESCALE_ADDR = 32'hBFF0;
  localparam int unsigned MTIME_ADDR    = 32'hBFF8;

  // Byte-lane merge of a write into an existing 64-bit register view.
  function automatic logic [63:0] be_merge(input logic [63:0] old_v,
                                           input logic [63:0] new_v,
                                           input logic [7:0]  be);
    logic [63:0] res;
    res = old_v;
    for (int b = 0; b < 8; b++) begin
      if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  logic [63:0]          mtime_q,    mtime_d;
  logic [63:0]          mtimecmp_q [NR_CORES];
  logic [63:0]          mtimecmp_d [NR_CORES];
  logic [NR_CORES-1:0]  msip_q,     msip_d;
  logic [PW-1:0]        prescale_q, prescale_d;
  logic [PW-1:0]        cnt_q,      cnt_d;
  logic [NR_CORES-1:0]  irq_q,      irq_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [63:0]          rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q,   rsp_err_d;

  logic                 halt_c;
  logic                 tick_c;
  logic                 req_ready_c;
  logic                 accept_c;
  logic                 wr_c;
  logic                 aligned_c;
  logic                 in_msip_c;
  logic                 in_cmp_c;
  logic                 is_pre_c;
  logic                 is_mtime_c;
  logic                 err_c;
  logic [IDX_W-1:0]     hart_c;
  logic [63:0]          rdata_c;

`ifdef CLINT_DBG_HALT_EN
  assign halt_c = debug_halt_i;
`else
  assign halt_c = 1'b0;
`endif

  assign req_ready_c = !rsp_valid_q || bus.rsp_ready_i;
  assign accept_c    = bus.req_valid_i && req_ready_c;

  // Address decode; hart slots beyond NR_CORES fall outside the windows and are unmapped.
  always_comb begin
    aligned_c  = (bus.req_addr_i[2:0] == 3'b000);
    in_msip_c  = aligned_c &&
                 (bus.req_addr_i >= AW'(MSIP_BASE)) &&
                 (bus.req_addr_i <  AW'(MSIP_BASE + WIN_BYTES));
    in_cmp_c   = aligned_c &&
                 (bus.req_addr_i >= AW'(MTIMECMP_BASE)) &&
                 (bus.req_addr_i <  AW'(MTIMECMP_BASE + WIN_BYTES));
    is_pre_c   = (bus.req_addr_i == AW'(PRESCALE_ADDR));
    is_mtime_c = (bus.req_addr_i == AW'(MTIME_ADDR));
    err_c      = !(in_msip_c || in_cmp_c || is_pre_c || is_mtime_c);
    hart_c     = bus.req_addr_i[3 +: IDX_W];
    wr_c       = accept_c && bus.req_we_i && !err_c;
  end

  // Read mux on pre-edge register state.
  always_comb begin
    rdata_c = 64'd0;
    if (in_msip_c) begin
      rdata_c = {63'd0, msip_q[hart_c]};
    end else if (in_cmp_c) begin
      rdata_c = mtimecmp_q[hart_c];
    end else if (is_pre_c) begin
      rdata_c = 64'(prescale_q);
    end else if (is_mtime_c) begin
      rdata_c = mtime_q;
    end
  end

  assign tick_c = !halt_c && (cnt_q == prescale_q);

  // Next-state for timer, register file, irqs and response.
  always_comb begin
    cnt_d       = cnt_q;
    prescale_d  = prescale_q;
    mtime_d     = mtime_q;
    msip_d      = msip_q;
    mtimecmp_d  = mtimecmp_q;
    irq_d       = irq_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    if (!halt_c) begin
      cnt_d = tick_c ? '0 : cnt_q + PW'(1);
    end
    if (tick_c) begin
      mtime_d = mtime_q + 64'd1;
    end

    // A software write overrides the tick; partial writes merge with the un-incremented value.
    if (wr_c) begin
      if (is_pre_c) begin
        prescale_d = PW'(be_merge(64'(prescale_q), bus.req_wdata_i, bus.req_be_i));
        cnt_d      = '0;
      end
      if (is_mtime_c) begin
        mtime_d = be_merge(mtime_q, bus.req_wdata_i, bus.req_be_i);
      end
      if (in_msip_c && bus.req_be_i[0]) begin
        msip_d[hart_c] = bus.req_wdata_i[0];
      end
      if (in_cmp_c) begin
        mtimecmp_d[hart_c] = be_merge(mtimecmp_q[hart_c], bus.req_wdata_i, bus.req_be_i);
      end
    end

    for (int i = 0; i < NR_CORES; i++) begin
      irq_d[i] = (mtime_q >= mtimecmp_q[i]);
    end

    if (accept_c) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = err_c;
      rsp_rdata_d = (bus.req_we_i || err_c) ? 64'd0 : rdata_c;
    end else if (bus.rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q     <= 64'd0;
      msip_q      <= '0;
      prescale_q  <= PW'(PRESCALE_RST);
      cnt_q       <= '0;
      irq_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
      rsp_err_q   <= 1'b0;
      for (int i = 0; i < NR_CORES; i++) begin
        mtimecmp_q[i] <= '1;
      end
    end else begin
      mtime_q     <= mtime_d;
      msip_q      <= msip_d;
      prescale_q  <= prescale_d;
      cnt_q       <= cnt_d;
      irq_q       <= irq_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      for (int i = 0; i < NR_CORES; i++) begin
        mtimecmp_q[i] <= mtimecmp_d[i];
      end
    end
  end

  assign bus.req_ready_o = req_ready_c;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign timer_irq_o     = irq_q;
  // The msip register itself drives ipi, so it is visible the cycle after the write edge.
  assign ipi_o           = msip_q;

endmodule

// File: doc/clint_timer_gen2.md
Name: clint_timer_gen2

Overview:
- Parametrised core-local interruptor for N harts: free-running 64-bit mtime, per-core mtimecmp and msip, with timer and software interrupt outputs.
- Replaces the fixed divide-by-two RTC with a runtime-programmable prescaler.
- Uses a simple valid/ready register port instead of a raw AXI struct port; it sits behind the SoC AXI-to-register bridge.

Parameters:
- NR_CORES, 1, number of harts: mtimecmp/msip register pairs and irq bits (1..64).
- ADDR_WIDTH, 16, register port address width (min 16).
- PRESCALE_RST, 1, reset value of the prescaler register; mtime ticks every PRESCALE+1 clk_i cycles.
- PRESCALE_WIDTH, 16, width of the prescaler register and counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_valid_i  in  1  register request valid
- req_ready_o  out  1  register request accepted
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  ADDR_WIDTH  byte address; 8-byte aligned
- req_wdata_i  in  64  write data
- req_be_i  in  8  byte enables for writes
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  64  read data (0 for writes)
- rsp_err_o  out  1  unmapped address or unaligned access
- timer_irq_o  out  NR_CORES  timer interrupt per hart
- ipi_o  out  NR_CORES  software interrupt per hart

Behaviour:
- Register map (offsets):
  - 0x0000 + 8*i: msip[i]; bit 0 is significant, other bits read 0. Packed one per doubleword, 64-bit view.
  - 0x4000 + 8*i: mtimecmp[i], 64-bit.
  - 0xBFF0: prescale, PRESCALE_WIDTH bits, zero-extended on read.
  - 0xBFF8: mtime, 64-bit.
  - Any other address, or addr[2:0] != 0: rsp_err_o = 1, no state change, rdata = 0.
- Reset values: mtime = 0, mtimecmp = all ones, msip = 0, prescale = PRESCALE_RST, prescale counter = 0.
- Output reset values: timer_irq_o = 0, ipi_o = 0, rsp_valid_o = 0, rsp_err_o = 0, rsp_rdata_o = 0.
- Handshake:
  - Single outstanding transaction. req_ready_o = !rsp_valid_o || rsp_ready_i.
  - Request accepted on req_valid_i && req_ready_o.
  - Response registered: rsp_valid_o rises the cycle after acceptance and holds, with stable data, until rsp_ready_i.
  - Back-to-back accept permitted when the response is consumed in the same cycle.
- Writes:
  - Byte-granular via req_be_i and take effect at the accept edge.
  - Reads return register state before any write at the same edge.
- Prescaler:
  - Counter increments each cycle. When counter == prescale, the counter clears and tick pulses for one cycle; mtime increments by 1 on tick.
  - prescale = 0 means mtime ticks every cycle.
  - A write to prescale clears the counter at the same edge.
- mtime wraps 0xFFFF_FFFF_FFFF_FFFF -> 0; no flag.
- Software write to mtime in the same cycle as a tick: written value wins, no increment. Partial byte writes merge with the un-incremented value.
- timer_irq_o[i]:
  - Registered from (mtime >= mtimecmp[i]), unsigned compare on current register values.
  - Asserts 1 cycle after the condition becomes true; deasserts 1 cycle after mtimecmp is raised above mtime.
- ipi_o[i]: registered msip[i][0], visible the cycle after the write edge.
- Reset mid-transaction: pending response dropped, rsp_valid_o = 0 the cycle after rst_i; all registers return to reset values.
- Hart index i >= NR_CORES within the msip/mtimecmp windows: treated as unmapped.

Optional Feature:
- Macro CLINT_DBG_HALT_EN.
- Defined:
  - Adds input debug_halt_i, 1 bit.
  - While high, the prescaler counter and mtime freeze, with no tick; register accesses still function.
  - Counting resumes from the frozen counter value the cycle after deassertion.
- Undefined: port absent; mtime always counts.

Test Plan:
- Reset, NR_CORES=2 -> read 0xBFF8 = 0, 0x4000 = 0xFFFF_FFFF_FFFF_FFFF, 0xBFF0 = 1; timer_irq_o = 2'b00, ipi_o = 2'b00.
- prescale=3, then sample mtime after 40 cycles from the prescale write -> mtime advanced by exactly 10.
- Set mtime = 0x10, mtimecmp[1] = 0x14, prescale = 0 -> timer_irq_o[1] rises exactly 1 cycle after mtime reads 0x14, and timer_irq_o[0] stays 0.
- Write mtimecmp[1] = 0x1000 while irq is high -> timer_irq_o[1] falls the following cycle.
- Write msip[0] = 1 with be = 0x01 -> ipi_o[0] = 1 next cycle. Then write 0 with be = 0x00 -> ipi_o[0] stays 1.
- Read 0x0010 with NR_CORES=2 -> rsp_err_o = 1, rdata = 0. Hold rsp_ready_i low 5 cycles -> rsp_valid_o held and req_ready_o = 0 throughout.
- Write mtime = 0xFFFF_FFFF_FFFF_FFFF, prescale = 0 -> next tick wraps mtime to 0.
